// File: rtl/xor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xor_pkg
// Purpose : Shared constants for the xor_accum block.
//           - mode encodings for PAIR / FOLD
//           - two-state frame FSM encoding
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package xor_pkg;

  localparam logic MODE_PAIR = 1'b0;
  localparam logic MODE_FOLD = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/xor_accum_xorn.sv
`default_nettype none
// ============================================================================
// Module  : xor1 / xorn
// Purpose : Purely combinational bitwise XOR.
//           - xor1 : single-bit XOR cell
//           - xorn : W-bit XOR built from a generate loop of xor1 cells
// Ports   : a, b  in  W  operands
//           z     out W  a ^ b
// Rev     : 1.0  initial release
// ============================================================================
module xor1 (
  input  logic a,
  input  logic b,
  output logic z
);
  assign z = a ^ b;
endmodule

module xorn #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] z
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    xor1 u_xor1 (
      .a (a[i]),
      .b (b[i]),
      .z (z[i])
    );
  end
endmodule
`default_nettype wire

// File: rtl/xor_accum.sv
`default_nettype none
// ============================================================================
// Module  : xor_accum
// Purpose : Registered, valid/ready XOR unit.
//           PAIR mode emits x^y per beat; FOLD mode XOR-accumulates a frame
//           (terminated by in_last) and emits one result per frame.
// Ports   : clk, reset (sync, active-high)
//           in_valid/in_ready, in_mode, in_last, x[W], y[W]   input stream
//           out_valid/out_ready, out_data[W], out_beats[CW], out_sat
//           out_parity (only with XOR_ACCUM_PARITY_EN defined)
// Options : XOR_ACCUM_PARITY_EN adds out_parity = ^out_data, registered.
// Rev     : 1.0  initial release
// ============================================================================
module xor_accum
  import xor_pkg::*;
#(
  parameter int W         = 6,
  parameter int MAX_BEATS = 15,
  parameter int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic          in_last,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_beats,
  output logic          out_sat
`ifdef XOR_ACCUM_PARITY_EN
  ,
  output logic          out_parity
`endif
);

  localparam logic [CW:0] MAX_EXT = (CW + 1)'(MAX_BEATS);

  state_t        state, state_n;
  logic          mode, mode_n;
  logic [W-1:0]  acc, acc_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [W-1:0]  xy;
  logic [W-1:0]  acc_xy;
  logic          accept;

  // Result loaded into the output register on this edge
  logic          load;
  logic [W-1:0]  res_data;
  logic [CW-1:0] res_beats;
  logic          res_sat;

  // One extra bit so cnt+1 cannot wrap when MAX_BEATS+1 is a power of two
  logic [CW:0]   cnt_p1;
  logic          sat_next;
  logic [CW-1:0] beats_next;

  xorn #(.W(W)) u_xy (
    .a (x),
    .b (y),
    .z (xy)
  );

  xorn #(.W(W)) u_acc (
    .a (acc),
    .b (xy),
    .z (acc_xy)
  );

  // Output slot is free, or its occupant leaves this edge
  assign in_ready   = !reset && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;

  assign cnt_p1     = {1'b0, cnt} + (CW + 1)'(1);
  assign sat_next   = (cnt_p1 >= MAX_EXT);
  assign beats_next = sat_next ? CW'(MAX_BEATS) : cnt_p1[CW-1:0];

  always_comb begin
    state_n   = state;
    mode_n    = mode;
    acc_n     = acc;
    cnt_n     = cnt;
    load      = 1'b0;
    res_data  = '0;
    res_beats = '0;
    res_sat   = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (in_mode == MODE_PAIR || in_last) begin
            // PAIR beat or a single-beat FOLD frame
            load      = 1'b1;
            res_data  = xy;
            res_beats = CW'(1);
            res_sat   = (MAX_BEATS == 1);
          end else begin
            acc_n   = xy;
            cnt_n   = CW'(1);
            mode_n  = MODE_FOLD;
            state_n = S_ACC;
          end
        end
        S_ACC: begin
          if (!in_last) begin
            acc_n = acc_xy;
            cnt_n = beats_next;
          end else begin
            load      = 1'b1;
            res_data  = acc_xy;
            res_beats = beats_next;
            res_sat   = sat_next;
            acc_n     = '0;
            cnt_n     = '0;
            mode_n    = MODE_PAIR;
            state_n   = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      mode  <= MODE_PAIR;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      mode  <= mode_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
    end
  end

  // Single-entry output register; loads only when in_ready allowed the beat
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_beats <= res_beats;
      out_sat   <= res_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef XOR_ACCUM_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_parity <= 1'b0;
    end else if (load) begin
      out_parity <= ^res_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_xor_accum
// Purpose : Self-checking bench for xor_accum. A frame-level reference model
//           (running XOR, unbounded beat count clamped on emit) predicts the
//           output register and in_ready every cycle.
// Options : XOR_ACCUM_PARITY_EN also checks out_parity.
// Rev     : 1.0  initial release
// ============================================================================
module tb_xor_accum;

  localparam int W    = 6;
  localparam int MAXB = 15;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic          in_last;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_beats;
  logic          out_sat;
`ifdef XOR_ACCUM_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  xor_accum #(.W(W), .MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_sat   (out_sat)
`ifdef XOR_ACCUM_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  int tests  = 0;
  int errors = 0;

  // Reference model state
  bit           m_ov;
  logic [W-1:0] m_data;
  int           m_beats;
  bit           m_sat;
  bit           m_in_frame;
  logic [W-1:0] m_fx;
  int           m_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ov       = 1'b0;
    m_data     = '0;
    m_beats    = 0;
    m_sat      = 1'b0;
    m_in_frame = 1'b0;
    m_fx       = '0;
    m_n        = 0;
  endtask

  task automatic emit(input logic [W-1:0] d, input int n);
    m_ov    = 1'b1;
    m_data  = d;
    m_beats = (n > MAXB) ? MAXB : n;
    m_sat   = (n >= MAXB);
  endtask

  task automatic model_beat(input bit md, input bit lst, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!m_in_frame && (md == 1'b0 || lst)) begin
      emit(a ^ b, 1);
    end else begin
      m_in_frame = 1'b1;
      m_fx       = m_fx ^ a ^ b;
      m_n++;
      if (lst) begin
        emit(m_fx, m_n);
        m_in_frame = 1'b0;
        m_fx       = '0;
        m_n        = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_beats", 32'(out_beats), 32'(m_beats));
      chk("out_sat", 32'(out_sat), 32'(m_sat));
`ifdef XOR_ACCUM_PARITY_EN
      chk("out_parity", 32'(out_parity), 32'(^m_data));
`endif
    end
  endtask

  // One cycle: check registered outputs, drive new inputs, predict the edge
  task automatic step(input bit v, input bit md, input bit lst,
                      input logic [W-1:0] a, input logic [W-1:0] b, input bit ordy);
    bit exp_rdy;
    @(negedge clk);
    check_outs();
    in_valid  = v;
    in_mode   = md;
    in_last   = lst;
    x         = a;
    y         = b;
    out_ready = ordy;
    #1;
    exp_rdy = !m_ov || ordy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_ov && ordy) m_ov = 1'b0;
    if (v && exp_rdy) model_beat(md, lst, a, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    x         = '0;
    y         = '0;
    out_ready = 1'b1;
    model_clear();
    do_reset();

    // PAIR
    step(1'b1, 1'b0, 1'b0, 6'h2A, 6'h15, 1'b1);
    @(posedge clk); #1;
    chk("pair_valid", 32'(out_valid), 32'd1);
    chk("pair_data", 32'(out_data), 32'h3F);
    chk("pair_beats", 32'(out_beats), 32'd1);
    chk("pair_sat", 32'(out_sat), 32'd0);
    idle(2);

    // FOLD, 3 beats
    step(1'b1, 1'b1, 1'b0, 6'h01, 6'h02, 1'b1);
    step(1'b1, 1'b1, 1'b0, 6'h04, 6'h08, 1'b1);
    step(1'b1, 1'b1, 1'b1, 6'h10, 6'h20, 1'b1);
    @(posedge clk); #1;
    chk("fold_data", 32'(out_data), 32'h3F);
    chk("fold_beats", 32'(out_beats), 32'd3);
    idle(2);

    // Backpressure then release
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, W'($urandom), W'($urandom), 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, W'($urandom), W'($urandom), 1'b1);
    idle(2);

    // Saturation: 20 beats of x=1
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, (i == 19), 6'h01, 6'h00, 1'b1);
    @(posedge clk); #1;
    chk("sat_data", 32'(out_data), 32'h00);
    chk("sat_beats", 32'(out_beats), 32'd15);
    chk("sat_flag", 32'(out_sat), 32'd1);
    idle(2);

    // Reset mid-frame
    step(1'b1, 1'b1, 1'b0, 6'h3C, 6'h01, 1'b1);
    step(1'b1, 1'b1, 1'b0, 6'h12, 6'h05, 1'b1);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 6'h07, 6'h00, 1'b1);
    @(posedge clk); #1;
    chk("midrst_data", 32'(out_data), 32'h07);
    chk("midrst_beats", 32'(out_beats), 32'd1);
    idle(3);

`ifdef XOR_ACCUM_PARITY_EN
    step(1'b1, 1'b0, 1'b0, 6'h07, 6'h00, 1'b1);
    @(posedge clk); #1;
    chk("parity_odd", 32'(out_parity), 32'd1);
    step(1'b1, 1'b0, 1'b0, 6'h03, 6'h00, 1'b1);
    @(posedge clk); #1;
    chk("parity_even", 32'(out_parity), 32'd0);
    idle(2);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 5) == 0,
             W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
      end
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xor_accum.md
Name: xor_accum

Overview:
- Parametrised, registered, handshaked successor to the 6-bit bitwise XOR unit.
- Takes two W-bit operands per beat over a valid/ready interface.
- Two modes:
  - PAIR: emits x^y for every beat.
  - FOLD: accumulates a running XOR checksum across a frame delimited by in_last and emits one result per frame.
- Sits between a stream source and the checksum/compare logic of the datapath.

Parameters:
- W, 6, operand and result width in bits (>=1).
- MAX_BEATS, 15, beat count at which the per-frame counter saturates (>=1).
- CW, $clog2(MAX_BEATS+1), beat-counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_mode  in  1  0=PAIR, 1=FOLD; sampled on the first beat of a frame only
- in_last  in  1  final beat of a FOLD frame; ignored in PAIR
- x  in  W  operand A
- y  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  W  result
- out_beats  out  CW  beats folded into this result (1 in PAIR)
- out_sat  out  1  frame reached MAX_BEATS beats (counter saturated)

Behaviour:
- Interface clocking and reset:
  - One clock domain. Reset is synchronous and active-high; clock port is clk, reset port is reset.
  - Reset values: out_valid=0, out_data=0, out_beats=0, out_sat=0, accumulator=0, beat counter=0, latched mode=PAIR, state=S_IDLE.
  - in_ready is combinational: in_ready = !out_valid || out_ready. It is 0 during reset.
- Handshakes:
  - Input accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data, out_beats and out_sat hold stable while out_valid && !out_ready.
- Output register is single-entry; there is no combinational path from in_valid to out_valid.
- State machine (states S_IDLE, S_ACC):
  - S_IDLE, accept, in_mode=0: out_data<=x^y, out_beats<=1, out_sat<=(MAX_BEATS==1), out_valid<=1. Stay in S_IDLE.
  - S_IDLE, accept, in_mode=1, in_last=1: same as PAIR (single-beat frame). Stay in S_IDLE.
  - S_IDLE, accept, in_mode=1, in_last=0: acc<=x^y, cnt<=1, latch FOLD, go to S_ACC. No output.
  - S_ACC, accept, in_last=0: acc<=acc^x^y, cnt<=min(cnt+1, MAX_BEATS). No output. in_mode is ignored.
  - S_ACC, accept, in_last=1: out_data<=acc^x^y, out_beats<=min(cnt+1, MAX_BEATS), out_sat<=(cnt+1>=MAX_BEATS), out_valid<=1. Clear acc and cnt, go to S_IDLE.
- Latency: one cycle from the accepting edge to out_valid.
- Full throughput of one beat per cycle when out_ready=1.
- While in S_ACC with a pending unread result, in_ready=0 until that result drains. This stalls the next frame; it does not lose data.
- Simultaneous events: when out_valid, out_ready and an input accept coincide, the old result transfers and the new result loads in the same edge.
- Saturation: cnt never wraps. Beats beyond MAX_BEATS still fold into acc; out_beats reports MAX_BEATS and out_sat=1.
- Reset mid-frame: the partial accumulator is discarded and no output is produced. The first beat after reset starts a new frame.
- Arithmetic: pure bitwise XOR, width W, no carries.

Optional Feature:
- Macro XOR_ACCUM_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit), equal to the reduction XOR of out_data.
  - It is registered with out_data and held under the same stall rules.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package xor_pkg holds:
  - mode constants MODE_PAIR=1'b0, MODE_FOLD=1'b1;
  - state encoding S_IDLE=1'b0, S_ACC=1'b1.
- Sub-module xorn (parameter W) performs the W-bit bitwise XOR.
  - It is a generate loop of xor1 instances and is purely combinational.
  - It is instantiated twice: once for x^y, once for acc^(x^y).

Test Plan:
- Reset then PAIR: x=6'h2A, y=6'h15, out_ready=1 -> next cycle out_valid=1, out_data=6'h3F, out_beats=1, out_sat=0.
- FOLD frame of 3 beats: (x,y)=(01,02),(04,08),(10,20) hex, last on the 3rd beat -> exactly one output, out_data=6'h3F, out_beats=3. No output after beats 1 and 2.
- Backpressure: PAIR beats with out_ready=0 for 4 cycles -> in_ready=0 after the first accept, out_data held stable. Release out_ready -> back-to-back results, none lost or duplicated.
- Saturation (MAX_BEATS=15): FOLD frame of 20 beats, each x=6'h01, y=0 -> out_data=6'h00, out_beats=15, out_sat=1.
- Reset mid-frame: 2 FOLD beats, assert reset 1 cycle, then PAIR x=6'h07, y=0 -> single output 6'h07, out_beats=1. No stale accumulator.
- XOR_ACCUM_PARITY_EN defined: PAIR x=6'h07, y=0 -> out_parity=1. With x=6'h03, y=0 -> out_parity=0.
